fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 27 ++
 rtl/fetch_queue.sv | 59 +++++
 rtl/fetch_unit.sv | 110 +++++++++++
 tb/tb_fetch_unit.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction fetch unit.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pkg;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] BUBBLE_INSTR     = 32'h0;
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

    function automatic logic [63:0] align_pc(input logic [63:0] addr);
        return {addr[63:2], 2'b00};
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_queue.sv
`default_nettype none
// ============================================================================
// Module      : fetch_queue
// Description : Small circular FIFO of fetched {pc, instr} entries.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    input  logic         clear,
    output logic [CW-1:0] count,
    output fetch_entry_t head
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t    r_mem [DEPTH];
    logic [PW-1:0]   r_rd_ptr;
    logic [PW-1:0]   r_wr_ptr;
    logic [CW-1:0]   r_count;

    // Explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push) r_wr_ptr <= next_ptr(r_wr_ptr);
            if (pop)  r_rd_ptr <= next_ptr(r_rd_ptr);
            r_count <= r_count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) r_mem[r_wr_ptr] <= push_data;
    end

    assign count = r_count;
    assign head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : In-order instruction fetch with bounded queue and flush drain.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [63:0] redirect_pc,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] Instruction,
    output logic [63:0] PC_Out,
    output logic        fetch_valid
);

    localparam int CW = $clog2(QDEPTH + 1);

    fetch_state_e  r_state;
    logic [63:0]   r_pc;
    logic [CW-1:0] r_inflight;
    logic [CW-1:0] r_drop_cnt;

    logic [CW-1:0] w_count;
    logic [CW:0]   w_outstanding;
    fetch_entry_t  w_head;
    fetch_entry_t  w_push_data;
    logic          w_accept;
    logic          w_push;
    logic          w_pop;
    logic          w_stale_rv;
    logic [CW-1:0] w_flush_drop;

    assign w_outstanding = {1'b0, r_inflight} + {1'b0, w_count};
    assign imem_req      = reset && (r_state == FETCH) && !flush
                           && (w_outstanding < (CW+1)'(QDEPTH));
    assign imem_addr     = r_pc;
    assign w_accept      = imem_req && imem_gnt;

    // Responses return in order, so the oldest outstanding request sits
    // inflight words behind the current pc.
    assign w_push            = imem_rvalid && (r_state == FETCH) && !flush && (r_inflight != '0);
    assign w_push_data.pc    = r_pc - (64'(r_inflight) << 2);
    assign w_push_data.instr = imem_rdata;

    assign fetch_valid = (w_count != '0);
    assign w_pop       = fetch_valid && !stall && !flush;
    assign Instruction = fetch_valid ? w_head.instr : BUBBLE_INSTR;
    assign PC_Out      = fetch_valid ? w_head.pc    : 64'h0;

    // A response arriving with the flush is already stale and is not waited for.
    assign w_stale_rv   = imem_rvalid && ((r_inflight != '0) || (r_drop_cnt != '0));
    assign w_flush_drop = r_inflight + r_drop_cnt + CW'(w_accept) - CW'(w_stale_rv);

    fetch_queue #(
        .DEPTH (QDEPTH)
    ) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (w_push),
        .push_data (w_push_data),
        .pop       (w_pop),
        .clear     (flush),
        .count     (w_count),
        .head      (w_head)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= FETCH;
            r_pc       <= RESET_PC;
            r_inflight <= '0;
            r_drop_cnt <= '0;
        end else if (flush) begin
            r_pc       <= align_pc(redirect_pc);
            r_inflight <= '0;
            r_drop_cnt <= w_flush_drop;
            r_state    <= (w_flush_drop != '0) ? DRAIN : FETCH;
        end else begin
            case (r_state)
                FETCH: begin
                    if (w_accept) r_pc <= r_pc + 64'd4;
                    r_inflight <= r_inflight + CW'(w_accept) - CW'(w_push);
                end
                DRAIN: begin
                    if (r_drop_cnt == '0) begin
                        r_state <= FETCH;
                    end else if (imem_rvalid) begin
                        r_drop_cnt <= r_drop_cnt - CW'(1);
                        if (r_drop_cnt == CW'(1)) r_state <= FETCH;
                    end
                end
                default: r_state <= FETCH;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Self-checking bench for fetch_unit with an in-order memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_unit;

    localparam int          QD      = 2;
    localparam logic [63:0] WRAP_PC = 64'hFFFF_FFFF_FFFF_FFFC;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [63:0] redirect_pc;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] Instruction;
    logic [63:0] PC_Out;
    logic        fetch_valid;
    logic        rsp_en;

    logic        w_zero;
    logic        w_one;
    logic [63:0] w_zero64;
    logic [31:0] w_zero32;
    logic        wr_req;
    logic [63:0] wr_addr;
    logic [31:0] wr_instr;
    logic [63:0] wr_pc;
    logic        wr_valid;

    int n_tests;
    int n_fail;

    fetch_unit #(.RESET_PC(64'h0), .QDEPTH(QD)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .Instruction(Instruction), .PC_Out(PC_Out), .fetch_valid(fetch_valid)
    );

    fetch_unit #(.RESET_PC(WRAP_PC), .QDEPTH(QD)) dut_wrap (
        .clk(clk), .reset(reset), .stall(w_zero), .flush(w_zero),
        .redirect_pc(w_zero64), .imem_req(wr_req), .imem_addr(wr_addr),
        .imem_gnt(w_one), .imem_rvalid(w_zero), .imem_rdata(w_zero32),
        .Instruction(wr_instr), .PC_Out(wr_pc), .fetch_valid(wr_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: fetched-entry queue, outstanding requests tagged stale
    // after a redirect, and the next fetch address.
    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } ment_t;
    typedef struct {
        logic [63:0] pc;
        bit          stale;
    } oreq_t;

    ment_t       mq[$];
    oreq_t       mo[$];
    logic [63:0] mpc;
    logic [63:0] memq[$];

    initial begin
        oreq_t       r;
        int          stale_n;
        bit          exp_req;
        bit          exp_valid;
        bit          pop_now;
        bit          push_now;
        logic [31:0] exp_instr;
        logic [63:0] exp_pc;
        mpc         = 64'h0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            if (reset !== 1'b1) begin
                chk("rst_req",   imem_req,    1'b0);
                chk("rst_valid", fetch_valid, 1'b0);
                chk("rst_instr", Instruction, 32'h0);
                chk("rst_pcout", PC_Out,      64'h0);
                chk("rst_addr",  imem_addr,   64'h0);
                mq.delete();
                mo.delete();
                memq.delete();
                mpc = 64'h0;
            end else begin
                stale_n = 0;
                foreach (mo[i]) if (mo[i].stale) stale_n++;
                exp_req   = !flush && (stale_n == 0) && ((mo.size() + mq.size()) < QD);
                exp_valid = (mq.size() > 0);
                exp_instr = exp_valid ? mq[0].instr : 32'h0;
                exp_pc    = exp_valid ? mq[0].pc    : 64'h0;
                chk("req",   imem_req,    exp_req);
                chk("addr",  imem_addr,   mpc);
                chk("valid", fetch_valid, exp_valid);
                chk("instr", Instruction, exp_instr);
                chk("pcout", PC_Out,      exp_pc);

                if (imem_rvalid && memq.size() > 0) void'(memq.pop_front());
                if (imem_req && imem_gnt) memq.push_back(imem_addr);

                pop_now  = exp_valid && !stall && !flush;
                push_now = 1'b0;
                if (imem_rvalid && mo.size() > 0) begin
                    r = mo.pop_front();
                    push_now = !r.stale && !flush;
                end
                if (flush) begin
                    mq.delete();
                    foreach (mo[i]) mo[i].stale = 1'b1;
                    mpc = {redirect_pc[63:2], 2'b00};
                end else begin
                    if (pop_now) void'(mq.pop_front());
                    if (push_now) mq.push_back('{r.pc, mem_word(r.pc)});
                    if (exp_req && imem_gnt) begin
                        mo.push_back('{mpc, 1'b0});
                        mpc = mpc + 64'd4;
                    end
                end
            end
            @(posedge clk);
            #2;
            imem_rvalid = rsp_en && (memq.size() > 0);
            imem_rdata  = imem_rvalid ? mem_word(memq[0]) : 32'h0;
        end
    end

    initial begin
        logic [15:0] gpat;
        int          n_rv;
        bit          saw_v;
        bit          got;
        n_tests = 0;
        n_fail  = 0;
        w_zero = 1'b0; w_one = 1'b1; w_zero64 = 64'h0; w_zero32 = 32'h0;
        reset = 1'b0; stall = 1'b0; flush = 1'b0; redirect_pc = 64'h0;
        imem_gnt = 1'b0; rsp_en = 1'b0;
        gpat = 16'b1011_0010_1110_0101;
        @(negedge clk);
        chk("wrap_rst_req", wr_req, 1'b0);
        repeat (2) @(posedge clk);

        // Zero-wait stream from reset release.
        #1; reset = 1'b1; imem_gnt = 1'b1; rsp_en = 1'b1;
        @(negedge clk);
        chk("c0_req",  imem_req,  1'b1);
        chk("c0_addr", imem_addr, 64'h0);
        chk("wrap_c0_addr", wr_addr, WRAP_PC);
        @(negedge clk);
        chk("c1_addr", imem_addr, 64'h4);
        chk("wrap_c1_addr", wr_addr, 64'h0);
        chk("wrap_c1_req",  wr_req,  1'b1);
        @(negedge clk);
        chk("c2_valid", fetch_valid, 1'b1);
        chk("c2_pcout", PC_Out, 64'h0);
        chk("c2_instr", Instruction, 32'h1357_9BDF);
        chk("c2_req_limit", imem_req, 1'b0);
        @(negedge clk);
        chk("c3_pcout", PC_Out, 64'h4);

        // Stall with head at 0x10.
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (fetch_valid && PC_Out == 64'h10) begin got = 1'b1; break; end
        end
        chk("wait_head_10", got, 1'b1);
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_pcout", PC_Out, 64'h10);
            chk("stall_instr", Instruction, 32'h1357_9BCF);
        end
        chk("stall_req_limit", imem_req, 1'b0);
        @(posedge clk); #1; stall = 1'b0;
        @(negedge clk);
        chk("resume_pc0", PC_Out, 64'h10);
        @(negedge clk);
        chk("resume_pc1", PC_Out, 64'h14);

        // Intermittent grants: address must hold while waiting.
        for (int i = 0; i < 24; i++) begin
            @(posedge clk); #1; imem_gnt = gpat[i % 16];
        end
        @(posedge clk); #1; imem_gnt = 1'b1;

        // Flush with two requests in flight.
        rsp_en = 1'b0;
        repeat (6) @(posedge clk);
        #1; flush = 1'b1; redirect_pc = 64'h1002;
        @(negedge clk);
        chk("flush_req", imem_req, 1'b0);
        @(posedge clk); #1; flush = 1'b0; rsp_en = 1'b1;
        n_rv = 0; saw_v = 1'b0; got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (imem_rvalid) n_rv++;
            if (fetch_valid) saw_v = 1'b1;
            if (imem_req) begin got = 1'b1; break; end
        end
        chk("drain_got_req", got, 1'b1);
        chk("drain_discards", n_rv, 2);
        chk("drain_no_valid", saw_v, 1'b0);
        chk("redirect_addr", imem_addr, 64'h1000);
        repeat (6) @(posedge clk);

        // Flush + stall + rvalid together, redirecting to the wrap address.
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #3;
            if (imem_rvalid) begin got = 1'b1; break; end
        end
        chk("wait_rvalid", got, 1'b1);
        flush = 1'b1; stall = 1'b1; redirect_pc = WRAP_PC;
        @(negedge clk);
        chk("fsr_req", imem_req, 1'b0);
        @(posedge clk); #1; flush = 1'b0; stall = 1'b0;
        @(negedge clk);
        chk("fsr_valid", fetch_valid, 1'b0);
        chk("fsr_addr", imem_addr, WRAP_PC);
        repeat (12) @(posedge clk);

        // Asynchronous reset while draining.
        #1; rsp_en = 1'b0;
        repeat (4) @(posedge clk);
        #1; flush = 1'b1; redirect_pc = 64'h2000;
        @(posedge clk); #1; flush = 1'b0;
        @(negedge clk);
        chk("drain_addr", imem_addr, 64'h2000);
        chk("drain_req", imem_req, 1'b0);
        @(posedge clk); #4; reset = 1'b0; #1;
        chk("arst_addr",  imem_addr,   64'h0);
        chk("arst_req",   imem_req,    1'b0);
        chk("arst_valid", fetch_valid, 1'b0);
        chk("arst_pcout", PC_Out,      64'h0);
        repeat (2) @(posedge clk);
        #1; reset = 1'b1; rsp_en = 1'b1;
        @(negedge clk);
        chk("rel_req",  imem_req,  1'b1);
        chk("rel_addr", imem_addr, 64'h0);
        repeat (10) @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
